// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: datapath widths, register-file
// address width helper and register-file FSM states.
package rv32i_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  function automatic int rf_aw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic {
    IDLE,
    CLEAR
  } rf_state_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: issue sets, writeback clears,
// the clear sequencer wipes one entry per cycle.
module rf_scoreboard #(
  parameter int  NREGS = rv32i_pkg::NREGS,
  localparam int AW    = rv32i_pkg::rf_aw(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_en,
  input  logic [AW-1:0]    clr_addr,
  input  logic             set_en,
  input  logic [AW-1:0]    set_addr,
  input  logic             wipe_en,
  input  logic [AW-1:0]    wipe_addr,
  output logic [NREGS-1:0] busy
);

  logic [NREGS-1:0] busy_nx;

  always_comb begin
    busy_nx = busy;
    if (wipe_en) begin
      busy_nx[wipe_addr] = 1'b0;
    end else begin
      if (clr_en) busy_nx[clr_addr] = 1'b0;
      // a new producer supersedes the retiring one
      if (set_en) busy_nx[set_addr] = 1'b1;
    end
    busy_nx[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= busy_nx;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port integer register file with write bypass,
// busy scoreboard and a sequenced synchronous clear.
module regfile_mp #(
  parameter int  XLEN   = rv32i_pkg::XLEN,
  parameter int  NREGS  = rv32i_pkg::NREGS,
  parameter int  NUM_RD = 2,
  parameter int  BYPASS = 1,
  localparam int AW     = rv32i_pkg::rf_aw(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_RD*AW-1:0]   rd_addr,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  output logic [NUM_RD-1:0]      rd_busy,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [XLEN-1:0]        wr_data,
  input  logic                   iss_en,
  input  logic [AW-1:0]          iss_addr,
  input  logic                   clr_req,
  output logic                   clr_busy
);

  import rv32i_pkg::*;

  rf_state_e        state;
  rf_state_e        state_nx;
  logic [AW-1:0]    cnt;
  logic [AW-1:0]    cnt_nx;
  logic [XLEN-1:0]  mem [NREGS];
  logic [NREGS-1:0] busy;
  logic             idle;
  logic             wr_ok;

  assign idle     = (state == IDLE);
  assign wr_ok    = wr_en & idle & (wr_addr != '0);
  assign clr_busy = ~idle;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (clr_req) begin
          state_nx = CLEAR;
          cnt_nx   = AW'(1);
        end
      end
      CLEAR: begin
        cnt_nx = cnt + AW'(1);
        if (cnt == AW'(NREGS - 1)) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (!idle) begin
        mem[cnt] <= '0;
      end else if (wr_ok) begin
        mem[wr_addr] <= wr_data;
      end
    end
  end

  rf_scoreboard #(
    .NREGS (NREGS)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_en    (wr_en & idle),
    .clr_addr  (wr_addr),
    .set_en    (iss_en & idle),
    .set_addr  (iss_addr),
    .wipe_en   (~idle),
    .wipe_addr (cnt),
    .busy      (busy)
  );

  // hit implies a nonzero address because wr_ok excludes x0
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [AW-1:0] a;
    logic          hit;
    assign a   = rd_addr[p*AW +: AW];
    assign hit = (BYPASS != 0) && wr_ok && (wr_addr == a);
    assign rd_data[p*XLEN +: XLEN] =
      hit        ? wr_data :
      (a == '0)  ? '0      : mem[a];
    assign rd_busy[p] =
      hit ? (iss_en && (iss_addr == a)) : busy[a];
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised bench for regfile_mp: two instances (bypass on/off)
// share stimulus and are checked against an array-based model.
module tb_regfile_mp;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int NUM_RD = 2;
  localparam int AW     = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic [NUM_RD*AW-1:0]   rd_addr  = '0;
  logic [NUM_RD*XLEN-1:0] rd_data1;
  logic [NUM_RD*XLEN-1:0] rd_data0;
  logic [NUM_RD-1:0]      rd_busy1;
  logic [NUM_RD-1:0]      rd_busy0;
  logic                   clr_busy1;
  logic                   clr_busy0;
  logic                   wr_en    = 1'b0;
  logic [AW-1:0]          wr_addr  = '0;
  logic [XLEN-1:0]        wr_data  = '0;
  logic                   iss_en   = 1'b0;
  logic [AW-1:0]          iss_addr = '0;
  logic                   clr_req  = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [XLEN-1:0] m_reg  [NREGS];
  bit              m_busy [NREGS];
  int              m_clr;

  always #5 clk = ~clk;

  regfile_mp #(
    .XLEN(XLEN), .NREGS(NREGS), .NUM_RD(NUM_RD), .BYPASS(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(rd_addr), .rd_data(rd_data1), .rd_busy(rd_busy1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .clr_req(clr_req), .clr_busy(clr_busy1)
  );

  regfile_mp #(
    .XLEN(XLEN), .NREGS(NREGS), .NUM_RD(NUM_RD), .BYPASS(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(rd_addr), .rd_data(rd_data0), .rd_busy(rd_busy0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .clr_req(clr_req), .clr_busy(clr_busy0)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) begin
      m_reg[i]  = '0;
      m_busy[i] = 1'b0;
    end
    m_clr = 0;
  endtask

  // m_clr == 0: idle; otherwise the register wiped at the next edge
  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_clr != 0) begin
      m_reg[m_clr]  = '0;
      m_busy[m_clr] = 1'b0;
      m_clr = (m_clr == NREGS - 1) ? 0 : m_clr + 1;
      return;
    end
    if (wr_en && wr_addr != 0) begin
      m_reg[wr_addr]  = wr_data;
      m_busy[wr_addr] = 1'b0;
    end
    if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
    if (clr_req) m_clr = 1;
  endtask

  task automatic compare();
    for (int p = 0; p < NUM_RD; p++) begin
      int a = int'(rd_addr[p*AW +: AW]);
      for (int b = 0; b < 2; b++) begin
        logic [XLEN-1:0] ed;
        logic            eb;
        logic [XLEN-1:0] gd;
        logic            gb;
        ed = (a == 0) ? '0 : m_reg[a];
        eb = (a != 0) && m_busy[a];
        if (b == 1 && m_clr == 0 && wr_en &&
            int'(wr_addr) == a && a != 0) begin
          ed = wr_data;
          eb = iss_en && int'(iss_addr) == a;
        end
        gd = b ? rd_data1[p*XLEN +: XLEN] : rd_data0[p*XLEN +: XLEN];
        gb = b ? rd_busy1[p] : rd_busy0[p];
        check($sformatf("p%0d_x%0d_data_byp%0d", p, a, b), 64'(gd), 64'(ed));
        check($sformatf("p%0d_x%0d_busy_byp%0d", p, a, b), 64'(gb), 64'(eb));
      end
    end
    check("clr_busy_byp1", 64'(clr_busy1), 64'(m_clr != 0));
    check("clr_busy_byp0", 64'(clr_busy0), 64'(m_clr != 0));
  endtask

  task automatic tick();
    #1;
    compare();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic set_rd(input int p, input int a);
    rd_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic set_idle();
    wr_en   = 1'b0;
    iss_en  = 1'b0;
    clr_req = 1'b0;
  endtask

  task automatic do_wr(input int a, input logic [XLEN-1:0] d);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
  endtask

  task automatic do_iss(input int a);
    iss_en   = 1'b1;
    iss_addr = AW'(a);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    model_reset();
    rst_n = 1'b0;
    @(negedge clk);
    tick();
    rst_n = 1'b1;

    for (int a = 1; a < NREGS; a++) begin
      set_rd(0, a);
      set_rd(1, NREGS - a);
      tick();
    end

    do_wr(5, 32'hDEADBEEF);
    set_rd(0, 1);
    set_rd(1, 2);
    tick();
    set_idle();
    set_rd(0, 5);
    set_rd(1, 0);
    tick();
    do_wr(0, 32'h1);
    tick();
    set_idle();
    set_rd(0, 0);
    tick();

    do_wr(7, 32'h1234);
    set_rd(1, 7);
    tick();
    set_idle();
    tick();

    do_iss(3);
    set_rd(0, 3);
    tick();
    set_idle();
    tick();
    do_wr(3, 32'h33);
    tick();
    set_idle();
    tick();
    do_iss(3);
    do_wr(3, 32'h44);
    tick();
    set_idle();
    tick();

    for (int a = 1; a < NREGS; a++) begin
      do_wr(a, XLEN'(a));
      do_iss(NREGS - a);
      tick();
    end
    set_idle();
    clr_req = 1'b1;
    tick();
    n = 0;
    for (int i = 0; i < 64; i++) begin
      do_wr(int'($urandom_range(1, NREGS - 1)), $urandom);
      do_iss(int'($urandom_range(1, NREGS - 1)));
      clr_req = 1'($urandom);
      set_rd(0, int'(wr_addr));
      set_rd(1, int'($urandom_range(0, NREGS - 1)));
      #1;
      if (!clr_busy1) break;
      n++;
      tick();
    end
    set_idle();
    check("clr_len", 64'(n), 64'(NREGS - 1));
    for (int a = 1; a < NREGS; a++) begin
      set_rd(0, a);
      set_rd(1, a);
      tick();
    end

    for (int a = 1; a < NREGS; a++) begin
      do_wr(a, ~XLEN'(a));
      tick();
    end
    set_idle();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      do_wr(int'($urandom_range(1, NREGS - 1)), $urandom);
      set_rd(0, NREGS - 1);
      set_rd(1, 20);
      tick();
    end
    set_idle();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_mid_clr_busy", 64'(clr_busy1), 64'(0));
    for (int a = 1; a < NREGS; a += 2) begin
      set_rd(0, a);
      set_rd(1, a + 1 < NREGS ? a + 1 : 0);
      tick();
    end
    rst_n = 1'b1;
    do_wr(9, 32'h55);
    tick();
    set_idle();
    set_rd(0, 9);
    set_rd(1, 31);
    tick();

    for (int i = 0; i < 3000; i++) begin
      wr_en    = 1'($urandom);
      wr_addr  = AW'($urandom);
      wr_data  = $urandom;
      iss_en   = 1'($urandom);
      iss_addr = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom);
      clr_req  = ($urandom_range(0, 99) == 0);
      for (int p = 0; p < NUM_RD; p++) begin
        if ($urandom_range(0, 1) == 0) set_rd(p, int'(wr_addr));
        else set_rd(p, int'($urandom_range(0, NREGS - 1)));
      end
      tick();
    end
    set_idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
